// File: rtl/path_delay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : path_delay_sequencer
//  Description : Trial sequencer for single-path delay characterisation.
//                Drives alternating rising/falling launches into the path,
//                strobes an external capture flop, compares the captured
//                value with the expected polarity and counts trials/errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module path_delay_sequencer #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned SETTLE  = 4,
   parameter bit          EXP_INV = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] trials_i,
   input  logic             ht_arm_i,
   input  logic             cap_q_i,
   output logic             path_in_o,
   output logic             ht_in1_o,
   output logic             ht_in2_o,
   output logic             cap_en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] trial_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRESET  = 3'd1,
      S_LAUNCH  = 3'd2,
      S_CAPTURE = 3'd3,
      S_CHECK   = 3'd4,
      S_FINISH  = 3'd5
   } state_t;

   // Settle counter counts down from SETTLE-1 to 0, giving SETTLE PRESET cycles.
   localparam logic [7:0]       C_SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;

   state_t           state_q,     state_d;
   logic             edge_q,      edge_d;
   logic             ht_arm_q,    ht_arm_d;
   logic [CNT_W-1:0] tgt_q,       tgt_d;
   logic [7:0]       settle_q,    settle_d;
   logic [CNT_W-1:0] trial_cnt_q, trial_cnt_d;
   logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
   logic             path_in_q,   path_in_d;
   logic             cap_en_q,    cap_en_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic             ht_q,        ht_d;

   logic             w_expected;
   logic             w_aborting;

   // The armed trigger inverts the path, so it flips the expected capture value.
   assign w_expected = edge_q ^ EXP_INV ^ ht_arm_q;
   assign w_aborting = abort_i && (state_q != S_IDLE);

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d     = state_q;
      edge_d      = edge_q;
      ht_arm_d    = ht_arm_q;
      tgt_d       = tgt_q;
      settle_d    = settle_q;
      trial_cnt_d = trial_cnt_q;
      err_cnt_d   = err_cnt_q;
      path_in_d   = path_in_q;
      cap_en_d    = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b0;
      ht_d        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               tgt_d       = trials_i;
               ht_arm_d    = ht_arm_i;
               trial_cnt_d = '0;
               err_cnt_d   = '0;
               edge_d      = 1'b1;
               if (trials_i == '0) begin
                  state_d = S_FINISH;
               end else begin
                  state_d  = S_PRESET;
                  settle_d = C_SETTLE_LAST;
               end
            end
         end
         S_PRESET: begin
            if (settle_q == 8'd0) begin
               state_d = S_LAUNCH;
            end else begin
               settle_d = settle_q - 8'd1;
            end
         end
         S_LAUNCH: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if ((cap_q_i != w_expected) && (err_cnt_q != C_CNT_MAX)) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
            trial_cnt_d = trial_cnt_q + 1'b1;
            edge_d      = ~edge_q;
            if (trial_cnt_d == tgt_q) begin
               state_d = S_FINISH;
            end else begin
               state_d  = S_PRESET;
               settle_d = C_SETTLE_LAST;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides any transition and freezes the run bookkeeping.
      if (w_aborting) begin
         state_d     = S_IDLE;
         edge_d      = edge_q;
         settle_d    = settle_q;
         trial_cnt_d = trial_cnt_q;
         err_cnt_d   = err_cnt_q;
      end

      // Outputs are derived from the state being entered so they are registered.
      unique case (state_d)
         S_PRESET: begin
            path_in_d = ~edge_d;
            busy_d    = 1'b1;
         end
         S_LAUNCH: begin
            path_in_d = edge_d;
            busy_d    = 1'b1;
         end
         S_CAPTURE: begin
            path_in_d = edge_d;
            cap_en_d  = 1'b1;
            busy_d    = 1'b1;
         end
         S_CHECK: begin
            busy_d = 1'b1;
         end
         S_FINISH: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase

      if (w_aborting) begin
         path_in_d = 1'b0;
         cap_en_d  = 1'b0;
         done_d    = 1'b0;
         busy_d    = 1'b0;
      end

      ht_d = busy_d ? ht_arm_d : 1'b0;
   end

   // State, counters and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         edge_q      <= 1'b1;
         ht_arm_q    <= 1'b0;
         tgt_q       <= '0;
         settle_q    <= 8'd0;
         trial_cnt_q <= '0;
         err_cnt_q   <= '0;
         path_in_q   <= 1'b0;
         cap_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ht_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         edge_q      <= edge_d;
         ht_arm_q    <= ht_arm_d;
         tgt_q       <= tgt_d;
         settle_q    <= settle_d;
         trial_cnt_q <= trial_cnt_d;
         err_cnt_q   <= err_cnt_d;
         path_in_q   <= path_in_d;
         cap_en_q    <= cap_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ht_q        <= ht_d;
      end
   end

   assign path_in_o   = path_in_q;
   assign ht_in1_o    = ht_q;
   assign ht_in2_o    = ht_q;
   assign cap_en_o    = cap_en_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign trial_cnt_o = trial_cnt_q;
   assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire
